cache_miss_ctrl: RTL and testbench

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_miss_ctrl.sv | 130 +++++++++++++
 tb/tb_cache_miss_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_miss_ctrl
// Purpose  : Read-miss controller. It looks up the cache, fetches a line from
//            memory on a miss, fills the cache and returns one word.
// Revision : 1.0  initial release
// ============================================================================
module cache_miss_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int WORD_W      = 32,
    parameter int LINE_W      = 128,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic              cache_lookup,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_hit,
    input  logic [WORD_W-1:0] cache_rdata,
    output logic              cache_fill,
    output logic [LINE_W-1:0] cache_fill_data,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_line,
    output logic [13:0]       hit_count,
    output logic [13:0]       access_count
);

    localparam int          c_OFF_W   = $clog2(LINE_W / WORD_W);
    localparam int          c_CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [13:0] c_CNT_MAX = 14'h3FFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_MISS_WAIT = 3'd2,
        S_FILL      = 3'd3,
        S_RESPOND   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_CNT_W-1:0]   r_wait;
    logic                 w_timeout;
    logic [c_OFF_W-1:0]   w_off;

    // Timeout fires on the last allowed MISS_WAIT cycle; mem_ready is checked first.
    assign w_timeout = (r_wait == c_CNT_W'(MEM_TIMEOUT - 1));
    assign w_off     = r_addr[c_OFF_W-1:0];

    assign req_ready    = (r_state == S_IDLE);
    assign cache_lookup = (r_state == S_LOOKUP);
    assign mem_read     = (r_state == S_MISS_WAIT);
    assign cache_fill   = (r_state == S_FILL);
    assign rsp_valid    = (r_state == S_RESPOND);
    assign cache_addr   = r_addr;
    assign mem_addr     = {r_addr[ADDR_W-1:c_OFF_W], c_OFF_W'(0)};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (req_valid) w_next = S_LOOKUP;
            S_LOOKUP:    w_next = cache_hit ? S_RESPOND : S_MISS_WAIT;
            S_MISS_WAIT: begin
                if (mem_ready)      w_next = S_FILL;
                else if (w_timeout) w_next = S_RESPOND;
            end
            S_FILL:      w_next = S_RESPOND;
            S_RESPOND:   if (rsp_ready) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_wait          <= '0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
            cache_fill_data <= '0;
            hit_count       <= '0;
            access_count    <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (r_state == S_MISS_WAIT) ? r_wait + 1'b1 : '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr <= req_addr;
                        if (access_count != c_CNT_MAX) access_count <= access_count + 1'b1;
                    end
                end
                S_LOOKUP: begin
                    rsp_err <= 1'b0;
                    if (cache_hit) begin
                        rsp_data <= cache_rdata;
                        if (hit_count != c_CNT_MAX) hit_count <= hit_count + 1'b1;
                    end
                end
                S_MISS_WAIT: begin
                    if (mem_ready) begin
                        cache_fill_data <= mem_line;
                    end else if (w_timeout) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                S_FILL: begin
                    rsp_data <= cache_fill_data[WORD_W*int'(w_off) +: WORD_W];
                end
                S_RESPOND: begin
                    if (rsp_ready) rsp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_miss_ctrl
// Purpose  : Directed self-checking bench for cache_miss_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [14:0]  req_addr;
    logic         rsp_valid, rsp_err, rsp_ready;
    logic [31:0]  rsp_data;
    logic         cache_lookup, cache_hit, cache_fill, mem_read, mem_ready;
    logic [14:0]  cache_addr, mem_addr;
    logic [31:0]  cache_rdata;
    logic [127:0] cache_fill_data, mem_line;
    logic [13:0]  hit_count, access_count;

    int passed = 0;
    int total  = 0;
    int fill_cnt = 0, mrd_cnt = 0, rv_cnt = 0;
    int snap_fill, snap_mrd, snap_rv;
    int n, cyc;
    logic [31:0] held;

    always #5 clk = ~clk;

    cache_miss_ctrl #(
        .ADDR_W(15), .WORD_W(32), .LINE_W(128), .MEM_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .cache_lookup(cache_lookup), .cache_addr(cache_addr),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .cache_fill(cache_fill), .cache_fill_data(cache_fill_data),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_line(mem_line),
        .hit_count(hit_count), .access_count(access_count)
    );

    // Cycle-level activity seen by the DUT at each active edge.
    always @(posedge clk) begin
        if (cache_fill) fill_cnt++;
        if (mem_read)   mrd_cnt++;
        if (rsp_valid)  rv_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        cache_hit = 1'b0; cache_rdata = '0; mem_ready = 1'b0; mem_line = '0;
        #3;
        check("rst_req_ready", req_ready, 1);
        check("rst_outputs", {rsp_valid, rsp_err, cache_lookup, cache_fill, mem_read}, 0);
        check("rst_regs", {rsp_data, cache_fill_data, mem_addr, cache_addr}, 0);
        check("rst_counters", {hit_count, access_count}, 0);
        @(negedge clk); rst = 1'b0;

        // ---- hit with response backpressure ----
        snap_mrd = mrd_cnt;
        req_valid = 1'b1; req_addr = 15'h0014; cache_hit = 1'b1; cache_rdata = 32'hDEADBEEF;
        tick;
        check("hit_lookup", cache_lookup, 1);
        check("hit_cache_addr", cache_addr, 15'h0014);
        check("hit_not_valid_yet", rsp_valid, 0);
        req_addr = 15'h0055;
        tick;
        check("hit_rsp_valid", rsp_valid, 1);
        check("hit_rsp_data", rsp_data, 32'hDEADBEEF);
        check("hit_counts", {hit_count, access_count}, {14'd1, 14'd1});
        for (int i = 0; i < 10; i++) begin
            tick;
            check("bp_valid_held", rsp_valid, 1);
            check("bp_data_held", rsp_data, 32'hDEADBEEF);
            check("bp_req_ready", req_ready, 0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick;
        check("hit_done", {rsp_valid, req_ready}, 2'b01);
        check("bp_second_ignored", access_count, 1);
        check("hit_no_mem_read", mrd_cnt - snap_mrd, 0);

        // ---- miss with fill after 5 wait cycles ----
        rsp_ready = 1'b0; snap_fill = fill_cnt;
        req_valid = 1'b1; req_addr = 15'h0016; cache_hit = 1'b0;
        mem_line = 128'h44444444_33333333_22222222_11111111;
        tick;
        req_valid = 1'b0;
        tick;
        check("miss_mem_read", mem_read, 1);
        check("miss_mem_addr", mem_addr, 15'h0014);
        repeat (4) tick;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        check("miss_fill", {cache_fill, mem_read, rsp_valid}, 3'b100);
        check("miss_fill_data", cache_fill_data, 128'h44444444_33333333_22222222_11111111);
        tick;
        check("miss_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("miss_rsp_data", rsp_data, 32'h33333333);
        check("miss_counts", {hit_count, access_count}, {14'd1, 14'd2});
        check("miss_one_fill", fill_cnt - snap_fill, 1);
        rsp_ready = 1'b1;
        tick;

        // ---- timeout, memory never answers ----
        rsp_ready = 1'b0; snap_fill = fill_cnt;
        req_valid = 1'b1; req_addr = 15'h0021;
        tick;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick;
            n++;
        end
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_data", rsp_data, 0);
        check("to_no_fill", fill_cnt - snap_fill, 0);
        rsp_ready = 1'b1;
        tick;
        check("to_err_cleared", rsp_err, 0);

        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 15'h0030;
        cache_hit = 1'b1; cache_rdata = 32'h12345678;
        tick;
        req_valid = 1'b0;
        tick;
        check("after_to_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("after_to_data", rsp_data, 32'h12345678);
        rsp_ready = 1'b1;
        tick;

        // ---- mem_ready on the final allowed wait cycle ----
        rsp_ready = 1'b0; cache_hit = 1'b0;
        req_valid = 1'b1; req_addr = 15'h0042;
        mem_line = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
        tick;
        req_valid = 1'b0;
        tick;
        repeat (7) tick;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        check("edge_fill", {cache_fill, rsp_valid}, 2'b10);
        tick;
        check("edge_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("edge_rsp_data", rsp_data, 32'hB1B1B1B1);
        check("edge_counts", {hit_count, access_count}, {14'd2, 14'd5});
        rsp_ready = 1'b1;
        tick;

        // ---- reset while waiting on memory ----
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 15'h0077;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        check("rm_mem_read", mem_read, 1);
        #2 rst = 1'b1;
        #1;
        check("rm_mem_read_drop", mem_read, 0);
        check("rm_outputs", {req_ready, rsp_valid, rsp_err, cache_lookup, cache_fill}, 5'b10000);
        check("rm_regs", {rsp_data, cache_fill_data, mem_addr, cache_addr}, 0);
        check("rm_counters", {hit_count, access_count}, 0);
        @(negedge clk); rst = 1'b0;
        snap_fill = fill_cnt; snap_rv = rv_cnt;
        mem_ready = 1'b1;
        repeat (10) tick;
        mem_ready = 1'b0;
        check("rm_no_rsp", rv_cnt - snap_rv, 0);
        check("rm_no_fill", fill_cnt - snap_fill, 0);
        check("rm_idle", req_ready, 1);

        // ---- counter saturation ----
        cache_hit = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 15'h0001;
        n = 0; cyc = 0;
        while (n < 16400 && cyc < 60000) begin
            @(negedge clk);
            if (rsp_valid) n++;
            cyc++;
        end
        req_valid = 1'b0;
        check("sat_responses", n, 16400);
        repeat (3) tick;
        check("sat_access", access_count, 14'd16383);
        check("sat_hit", hit_count, 14'd16383);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
